// File: rtl/pe_fork_multi.sv
// pe_fork_multi: join-compute-fork processing element.
//
// Joins NUM_OUT+1 valid/ready input streams (input 0 is the shared operand a,
// input k+1 is lane k's private operand b_k), computes r_k = a OP_k b_k for
// every lane and pushes each result into that lane's FIFO. Each lane FIFO
// drains independently through its own valid/ready output.
//
// Ports:
//   clk, rst     clock (rising edge) and synchronous active-high reset
//   in_valid     per-input valid, bit 0 = operand a
//   in_ready     per-input ready (all bits equal: join is all-or-nothing)
//   in_data      input i at [i*DATA_WIDTH +: DATA_WIDTH]
//   cfg_op       lane k op at [2k +: 2]: 00 ADD, 01 SUB, 10 AND, 11 XOR
//   out_valid    per-lane valid (lane FIFO not empty)
//   out_ready    per-lane ready
//   out_data     lane k head at [k*DATA_WIDTH +: DATA_WIDTH]
//   fire_count   number of joined tokens accepted since reset (wraps)
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. Valid never depends on ready; output data is held stable while
// valid is high and ready is low.
module pe_fork_multi #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_OUT    = 2,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_OUT:0]                  in_valid,
  output logic [NUM_OUT:0]                  in_ready,
  input  logic [(NUM_OUT+1)*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_OUT*2-1:0]              cfg_op,
  output logic [NUM_OUT-1:0]                out_valid,
  input  logic [NUM_OUT-1:0]                out_ready,
  output logic [NUM_OUT*DATA_WIDTH-1:0]     out_data,
  output logic [CNT_WIDTH-1:0]              fire_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH + 1);

  logic [NUM_OUT-1:0]   lane_not_full;
  logic                 fire;
  logic [CNT_WIDTH-1:0] fire_cnt_d, fire_cnt_q;

  // A full lane blocks the join even if it is being popped this cycle:
  // there is deliberately no full-and-pop bypass.
  assign fire       = !rst && (&in_valid) && (&lane_not_full);
  assign in_ready   = {(NUM_OUT+1){fire}};
  assign fire_count = fire_cnt_q;

  always_comb begin
    fire_cnt_d = fire_cnt_q;
    if (fire) fire_cnt_d = fire_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) fire_cnt_q <= '0;
    else     fire_cnt_q <= fire_cnt_d;
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_lane
    logic [DATA_WIDTH-1:0] op_a, op_b, result;
    logic [1:0]            op_sel;
    logic                  push, pop;
    logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_d, wr_ptr_q, rd_ptr_d, rd_ptr_q;
    logic [OCC_W-1:0]      occ_d, occ_q;

    assign op_a   = in_data[0 +: DATA_WIDTH];
    assign op_b   = in_data[(k+1)*DATA_WIDTH +: DATA_WIDTH];
    assign op_sel = cfg_op[2*k +: 2];

    // Op is applied at the fire cycle; the FIFO stores finished results,
    // so later cfg_op changes cannot alter queued entries.
    always_comb begin
      result = '0;
      case (op_sel)
        2'b00:   result = op_a + op_b;
        2'b01:   result = op_a - op_b;
        2'b10:   result = op_a & op_b;
        default: result = op_a ^ op_b;
      endcase
    end

    assign lane_not_full[k] = (occ_q != OCC_W'(FIFO_DEPTH));
    assign out_valid[k]     = (occ_q != '0);
    assign out_data[k*DATA_WIDTH +: DATA_WIDTH] = mem_q[rd_ptr_q];

    assign push = fire;
    assign pop  = out_valid[k] && out_ready[k];

    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (push) begin
        mem_d[wr_ptr_q] = result;
        wr_ptr_d = (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push, pop})
        2'b10:   occ_d = occ_q + 1'b1;
        2'b01:   occ_d = occ_q - 1'b1;
        default: occ_d = occ_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        occ_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        occ_q    <= occ_d;
      end
    end

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_pe_fork_multi.sv
// Directed testbench for pe_fork_multi (DATA_WIDTH=32, NUM_OUT=2,
// FIFO_DEPTH=2, CNT_WIDTH=16). Inputs are driven on the falling edge and
// outputs are sampled shortly after the falling edge.
module tb_pe_fork_multi;

  localparam int DW = 32;
  localparam int NO = 2;

  logic            clk;
  logic            rst;
  logic [NO:0]     in_valid;
  logic [NO:0]     in_ready;
  logic [(NO+1)*DW-1:0] in_data;
  logic [NO*2-1:0] cfg_op;
  logic [NO-1:0]   out_valid;
  logic [NO-1:0]   out_ready;
  logic [NO*DW-1:0] out_data;
  logic [15:0]     fire_count;

  int tests_run;
  int tests_failed;
  logic [15:0] exp_fire;
  logic [DW-1:0] exp_q[$];

  pe_fork_multi #(
    .DATA_WIDTH(32), .NUM_OUT(2), .FIFO_DEPTH(2), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .cfg_op(cfg_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .fire_count(fire_count)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic wait_sample();
    @(negedge clk);
  endtask

  task automatic drive_token(input logic [DW-1:0] a, input logic [DW-1:0] b0,
                             input logic [DW-1:0] b1);
    in_data  = {b1, b0, a};
    in_valid = 3'b111;
  endtask

  task automatic drive_idle();
    in_valid = 3'b000;
    in_data  = '0;
  endtask

  function automatic logic [DW-1:0] lane(input int k);
    return out_data[k*DW +: DW];
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 3'b111;
    in_data = '0;
    out_ready = 2'b11;
    cfg_op = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      wait_sample();
      #1;
      tests_run++;
      if (in_ready !== 3'b000) begin
        tests_failed++;
        $display("FAIL reset_in_ready_during_rst: got %b want 000", in_ready);
      end
    end
    drive_idle();
    rst = 1'b0;
    wait_sample();
    #1;
    tests_run++;
    if (out_valid !== 2'b00 || in_ready !== 3'b000 || fire_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_state: out_valid=%b in_ready=%b fire_count=%0d want 00 000 0",
               out_valid, in_ready, fire_count);
    end
    exp_fire = 16'd0;
  endtask

  task automatic test_basic();
    cfg_op = 4'b0100; // lane0 ADD, lane1 SUB
    out_ready = 2'b11;
    drive_token(32'd10, 32'd3, 32'd4);
    #1;
    tests_run++;
    if (in_ready !== 3'b111) begin
      tests_failed++;
      $display("FAIL basic_fire1: in_ready=%b want 111", in_ready);
    end
    wait_sample();
    exp_fire = exp_fire + 1'b1;
    drive_token(32'd7, 32'd9, 32'd2);
    #1;
    tests_run++;
    if (out_valid !== 2'b11 || lane(0) !== 32'd13 || lane(1) !== 32'd6) begin
      tests_failed++;
      $display("FAIL basic_tok1: valid=%b out0=%0d out1=%0d want 11 13 6",
               out_valid, lane(0), lane(1));
    end
    wait_sample();
    exp_fire = exp_fire + 1'b1;
    drive_idle();
    #1;
    tests_run++;
    if (out_valid !== 2'b11 || lane(0) !== 32'd16 || lane(1) !== 32'd5) begin
      tests_failed++;
      $display("FAIL basic_tok2: valid=%b out0=%0d out1=%0d want 11 16 5",
               out_valid, lane(0), lane(1));
    end
    wait_sample();
    #1;
    tests_run++;
    if (out_valid !== 2'b00 || fire_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL basic_drain: valid=%b fire_count=%0d want 00 2", out_valid, fire_count);
    end
  endtask

  task automatic test_wrap();
    cfg_op = 4'b0100;
    drive_token(32'hFFFF_FFFF, 32'd1, 32'd2);
    wait_sample();
    exp_fire = exp_fire + 1'b1;
    cfg_op = 4'b1110; // lane0 AND, lane1 XOR
    drive_token(32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0F0F_0F0F);
    #1;
    tests_run++;
    if (lane(0) !== 32'h0000_0000 || lane(1) !== 32'hFFFF_FFFD) begin
      tests_failed++;
      $display("FAIL wrap_addsub: out0=%h out1=%h want 00000000 fffffffd", lane(0), lane(1));
    end
    wait_sample();
    exp_fire = exp_fire + 1'b1;
    drive_idle();
    cfg_op = 4'b0000; // must not affect the queued result
    #1;
    tests_run++;
    if (out_valid !== 2'b11 || lane(0) !== 32'hF000_F000 || lane(1) !== 32'hFFFF_FFFF) begin
      tests_failed++;
      $display("FAIL logic_andxor: valid=%b out0=%h out1=%h want 11 f000f000 ffffffff",
               out_valid, lane(0), lane(1));
    end
    wait_sample();
    #1;
    tests_run++;
    if (fire_count !== exp_fire) begin
      tests_failed++;
      $display("FAIL wrap_fire_count: got %0d want %0d", fire_count, exp_fire);
    end
  endtask

  task automatic test_backpressure();
    int seen;
    cfg_op = 4'b0100;
    out_ready = 2'b01;
    exp_q.delete();
    exp_q.push_back(32'd90);
    exp_q.push_back(32'd180);
    exp_q.push_back(32'd270);
    drive_token(32'd100, 32'd1, 32'd10);
    #1;
    tests_run++;
    if (in_ready !== 3'b111) begin
      tests_failed++;
      $display("FAIL bp_accept1: in_ready=%b want 111", in_ready);
    end
    wait_sample();
    exp_fire = exp_fire + 1'b1;
    drive_token(32'd200, 32'd2, 32'd20);
    #1;
    tests_run++;
    if (in_ready !== 3'b111 || lane(0) !== 32'd101) begin
      tests_failed++;
      $display("FAIL bp_accept2: in_ready=%b out0=%0d want 111 101", in_ready, lane(0));
    end
    wait_sample();
    exp_fire = exp_fire + 1'b1;
    drive_token(32'd300, 32'd3, 32'd30);
    #1;
    tests_run++;
    if (in_ready !== 3'b000 || out_valid !== 2'b11 || lane(0) !== 32'd202) begin
      tests_failed++;
      $display("FAIL bp_hold3: in_ready=%b valid=%b out0=%0d want 000 11 202",
               in_ready, out_valid, lane(0));
    end
    for (int i = 0; i < 3; i++) begin
      wait_sample();
      #1;
      tests_run++;
      if (in_ready !== 3'b000 || out_valid !== 2'b10 || lane(1) !== 32'd90) begin
        tests_failed++;
        $display("FAIL bp_stall: in_ready=%b valid=%b out1=%0d want 000 10 90",
                 in_ready, out_valid, lane(1));
      end
    end
    wait_sample();
    out_ready = 2'b11;
    #1;
    // Full lane being popped must still refuse the push this cycle.
    tests_run++;
    if (in_ready !== 3'b000) begin
      tests_failed++;
      $display("FAIL bp_no_bypass: in_ready=%b want 000", in_ready);
    end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid[1]) begin
        tests_run++;
        if (exp_q.size() == 0 || lane(1) !== exp_q[0]) begin
          tests_failed++;
          $display("FAIL bp_lane1_order: got %0d want %0d", lane(1),
                   (exp_q.size() == 0) ? 0 : exp_q[0]);
        end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        seen++;
      end
      if (i == 1) begin
        tests_run++;
        if (in_ready !== 3'b111) begin
          tests_failed++;
          $display("FAIL bp_accept3: in_ready=%b want 111", in_ready);
        end
      end
      if (i == 2) begin
        tests_run++;
        if (out_valid[0] !== 1'b1 || lane(0) !== 32'd303) begin
          tests_failed++;
          $display("FAIL bp_out0_tok3: valid0=%b out0=%0d want 1 303", out_valid[0], lane(0));
        end
      end
      wait_sample();
      if (i == 1) begin
        exp_fire = exp_fire + 1'b1;
        drive_idle();
      end
      #1;
    end
    tests_run++;
    if (seen != 3 || out_valid !== 2'b00 || fire_count !== exp_fire) begin
      tests_failed++;
      $display("FAIL bp_final: lane1 pops=%0d valid=%b fire_count=%0d want 3 00 %0d",
               seen, out_valid, fire_count, exp_fire);
    end
  endtask

  task automatic test_partial_join();
    cfg_op = 4'b0100;
    out_ready = 2'b11;
    in_data = {32'd7, 32'd6, 32'd5};
    in_valid = 3'b011;
    for (int i = 0; i < 10; i++) begin
      #1;
      tests_run++;
      if (in_ready !== 3'b000 || out_valid !== 2'b00) begin
        tests_failed++;
        $display("FAIL partial_hold: in_ready=%b valid=%b want 000 00", in_ready, out_valid);
      end
      wait_sample();
    end
    in_valid = 3'b111;
    #1;
    tests_run++;
    if (in_ready !== 3'b111) begin
      tests_failed++;
      $display("FAIL partial_fire: in_ready=%b want 111", in_ready);
    end
    wait_sample();
    exp_fire = exp_fire + 1'b1;
    drive_idle();
    #1;
    tests_run++;
    if (out_valid !== 2'b11 || lane(0) !== 32'd11 || lane(1) !== 32'hFFFF_FFFE ||
        fire_count !== exp_fire) begin
      tests_failed++;
      $display("FAIL partial_result: valid=%b out0=%h out1=%h cnt=%0d want 11 0000000b fffffffe %0d",
               out_valid, lane(0), lane(1), fire_count, exp_fire);
    end
    wait_sample();
  endtask

  task automatic test_reset_mid_op();
    cfg_op = 4'b0100;
    out_ready = 2'b01;
    drive_token(32'd50, 32'd1, 32'd2);
    wait_sample();
    drive_token(32'd60, 32'd1, 32'd2);
    wait_sample();
    drive_token(32'd70, 32'd1, 32'd2);
    #1;
    tests_run++;
    if (out_valid[1] !== 1'b1 || in_ready !== 3'b000) begin
      tests_failed++;
      $display("FAIL midrst_queued: valid=%b in_ready=%b want 1x 000", out_valid, in_ready);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (in_ready !== 3'b000) begin
      tests_failed++;
      $display("FAIL midrst_in_ready: in_ready=%b want 000", in_ready);
    end
    wait_sample();
    rst = 1'b0;
    drive_idle();
    out_ready = 2'b11;
    #1;
    tests_run++;
    if (out_valid !== 2'b00 || fire_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL midrst_cleared: valid=%b fire_count=%0d want 00 0", out_valid, fire_count);
    end
    for (int i = 0; i < 3; i++) begin
      wait_sample();
      #1;
      tests_run++;
      if (out_valid !== 2'b00) begin
        tests_failed++;
        $display("FAIL midrst_no_stale: valid=%b want 00", out_valid);
      end
    end
    drive_token(32'd1, 32'd1, 32'd1);
    wait_sample();
    drive_idle();
    #1;
    tests_run++;
    if (out_valid !== 2'b11 || lane(0) !== 32'd2 || lane(1) !== 32'd0 || fire_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL midrst_fresh: valid=%b out0=%0d out1=%0d cnt=%0d want 11 2 0 1",
               out_valid, lane(0), lane(1), fire_count);
    end
    wait_sample();
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    exp_fire = '0;
    rst = 1'b1;
    in_valid = '0;
    in_data = '0;
    cfg_op = '0;
    out_ready = '0;
    wait_sample();
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_partial_join();
    test_reset_mid_op();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
